// File: rtl/truth_table_extractor_pkg.sv
// Shared types and constants for the truth-table extractor.
// Table width helper plus the 3-input AND reference table.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } tt_state_e;

    localparam logic [7:0] AND3_TT = 8'h80;

    function automatic int unsigned tt_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_extractor_if.sv
// Extractor-to-bench bundle: sweep handshake, DUT drive/observe and result.
// master = extractor side, slave = stimulus/consumer side.
interface truth_table_extractor_if
    import tt_pkg::*;
#(
    parameter int unsigned N_IN = 3
) ();

    localparam int unsigned TT_W = tt_width(N_IN);

    logic            start;
    logic            busy;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic [TT_W-1:0] tt;
    logic            unstable;
    logic            result_valid;
    logic            result_ready;

    modport master (
        input  start,
        input  dut_out,
        input  result_ready,
        output busy,
        output dut_in,
        output tt,
        output unstable,
        output result_valid
    );

    modport slave (
        output start,
        output dut_out,
        output result_ready,
        input  busy,
        input  dut_in,
        input  tt,
        input  unstable,
        input  result_valid
    );

endinterface

// File: rtl/truth_table_extractor_settle_timer.sv
// Per-vector hold counter: pulses on the last settle cycle and keeps
// a one-cycle-old copy of dut_out for the instability check.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic dut_out,
    output logic sample_pulse,
    output logic prev_dut_out
);

    localparam int unsigned     HOLD_W    = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYCLES);

    logic [HOLD_W-1:0] hold_q;
    logic              prev_q;

    assign sample_pulse = enable && (hold_q == HOLD_LAST);
    assign prev_dut_out = prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            prev_q <= 1'b0;
        end else begin
            prev_q <= dut_out;
            if (!enable || sample_pulse) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_extractor.sv
// Walks all 2**N_IN input vectors of a combinational block, samples its
// output after a settle window and returns the packed truth table.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_extractor_if.master bus
);

    localparam int unsigned TT_W     = tt_width(N_IN);
    localparam int unsigned VEC_W    = N_IN + 1;
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(TT_W - 1);
    localparam bit          CHECK_EN = (SETTLE_CYCLES != 0);

    tt_state_e        state_q;
    logic [VEC_W-1:0] vec_q;
    logic [TT_W-1:0]  tt_q;
    logic             unstable_q;
    logic             busy_q;
    logic             valid_q;

    logic sample_pulse;
    logic prev_dut_out;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk          (clk),
        .rst          (rst),
        .enable       (state_q == ST_RUN),
        .dut_out      (bus.dut_out),
        .sample_pulse (sample_pulse),
        .prev_dut_out (prev_dut_out)
    );

    // Sweep controller; vec_q carries one spare bit so the terminal compare is exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            tt_q       <= '0;
            unstable_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_RUN;
                        vec_q      <= '0;
                        tt_q       <= '0;
                        unstable_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sample_pulse) begin
                        tt_q[vec_q[N_IN-1:0]] <= bus.dut_out;
                        if (CHECK_EN && (bus.dut_out != prev_dut_out)) begin
                            unstable_q <= 1'b1;
                        end
                        if (vec_q == VEC_LAST) begin
                            state_q <= ST_RESULT;
                            vec_q   <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            vec_q <= vec_q + VEC_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (bus.result_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.dut_in       = vec_q[N_IN-1:0];
    assign bus.tt           = tt_q;
    assign bus.unstable     = unstable_q;
    assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench: 3-input AND extractor at defaults plus a 2-input XOR
// extractor with no settle window.
module tb_truth_table_extractor;
    import tt_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic force_en;
    logic force_val;

    always #5 clk = ~clk;

    truth_table_extractor_if #(.N_IN(3)) bus_a ();
    truth_table_extractor_if #(.N_IN(2)) bus_b ();

    // Gate blocks under characterization.
    assign bus_a.dut_out = force_en ? force_val : (&bus_a.dut_in);
    assign bus_b.dut_out = ^bus_b.dut_in;

    truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    truth_table_extractor #(.N_IN(2), .SETTLE_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep on A and return cycles from the start edge to result_valid.
    task automatic sweep_a(input int restart_at, input int force_at, output int lat);
        int n;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check_eq("a_busy_after_start", 64'(bus_a.busy), 64'd1);
        n = 0;
        while (!bus_a.result_valid && n < 100) begin
            tick();
            n++;
            bus_a.start = (n == restart_at);
            if (n == force_at) begin
                check_eq("a_dut_in_vec5", 64'(bus_a.dut_in), 64'd5);
                force_en  = 1'b1;
                force_val = 1'b1;
            end else begin
                force_en = 1'b0;
            end
        end
        bus_a.start = 1'b0;
        force_en    = 1'b0;
        lat         = n;
    endtask

    initial begin
        int lat;
        logic [1:0] exp_vec [4];

        rst                = 1'b1;
        force_en           = 1'b0;
        force_val          = 1'b0;
        bus_a.start        = 1'b0;
        bus_a.result_ready = 1'b0;
        bus_b.start        = 1'b0;
        bus_b.result_ready = 1'b0;
        repeat (3) tick();

        check_eq("rst_a_busy",  64'(bus_a.busy),         64'd0);
        check_eq("rst_a_dutin", 64'(bus_a.dut_in),       64'd0);
        check_eq("rst_a_tt",    64'(bus_a.tt),           64'd0);
        check_eq("rst_a_unst",  64'(bus_a.unstable),     64'd0);
        check_eq("rst_a_valid", 64'(bus_a.result_valid), 64'd0);
        check_eq("rst_b_valid", 64'(bus_b.result_valid), 64'd0);
        rst = 1'b0;
        tick();

        // AND sweep with a stray start mid-run.
        sweep_a(5, -1, lat);
        check_eq("and_latency", 64'(lat),                  64'd24);
        check_eq("and_tt",      64'(bus_a.tt),             64'(AND3_TT));
        check_eq("and_unst",    64'(bus_a.unstable),       64'd0);
        check_eq("and_busy",    64'(bus_a.busy),           64'd0);
        check_eq("and_dutin",   64'(bus_a.dut_in),         64'd0);
        // start together with result_ready: only the return to IDLE.
        bus_a.result_ready = 1'b1;
        bus_a.start        = 1'b1;
        tick();
        bus_a.result_ready = 1'b0;
        bus_a.start        = 1'b0;
        check_eq("and_release_valid", 64'(bus_a.result_valid), 64'd0);
        check_eq("and_release_busy",  64'(bus_a.busy),         64'd0);
        repeat (3) tick();
        check_eq("and_idle_no_sweep", 64'(bus_a.busy),         64'd0);
        check_eq("and_idle_tt_held",  64'(bus_a.tt),           64'(AND3_TT));

        // Glitch on the last settle cycle of vector 5.
        sweep_a(-1, 17, lat);
        check_eq("glitch_latency", 64'(lat),            64'd24);
        check_eq("glitch_tt",      64'(bus_a.tt),       64'hA0);
        check_eq("glitch_unst",    64'(bus_a.unstable), 64'd1);

        // Backpressure with a start pulse while the result is pending.
        for (int i = 0; i < 10; i++) begin
            bus_a.start = (i == 3);
            tick();
            check_eq("bp_valid", 64'(bus_a.result_valid), 64'd1);
            check_eq("bp_tt",    64'(bus_a.tt),           64'hA0);
            check_eq("bp_busy",  64'(bus_a.busy),         64'd0);
        end
        bus_a.start        = 1'b0;
        bus_a.result_ready = 1'b1;
        tick();
        bus_a.result_ready = 1'b0;
        check_eq("bp_release_valid", 64'(bus_a.result_valid), 64'd0);
        check_eq("bp_unst_held",     64'(bus_a.unstable),     64'd1);

        // Reset at cycle 12 of a sweep.
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (12) tick();
        check_eq("mid_busy", 64'(bus_a.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_busy",  64'(bus_a.busy),         64'd0);
        check_eq("mrst_dutin", 64'(bus_a.dut_in),       64'd0);
        check_eq("mrst_tt",    64'(bus_a.tt),           64'd0);
        check_eq("mrst_unst",  64'(bus_a.unstable),     64'd0);
        check_eq("mrst_valid", 64'(bus_a.result_valid), 64'd0);
        tick();
        sweep_a(-1, -1, lat);
        check_eq("post_rst_latency", 64'(lat),            64'd24);
        check_eq("post_rst_tt",      64'(bus_a.tt),       64'(AND3_TT));
        check_eq("post_rst_unst",    64'(bus_a.unstable), 64'd0);
        bus_a.result_ready = 1'b1;
        tick();
        bus_a.result_ready = 1'b0;

        // XOR, 2 inputs, no settle window.
        exp_vec[0] = 2'd0;
        exp_vec[1] = 2'd1;
        exp_vec[2] = 2'd2;
        exp_vec[3] = 2'd3;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("xor_dutin_seq", 64'(bus_b.dut_in),       64'(exp_vec[k]));
            check_eq("xor_not_valid", 64'(bus_b.result_valid), 64'd0);
            tick();
        end
        check_eq("xor_valid", 64'(bus_b.result_valid), 64'd1);
        check_eq("xor_tt",    64'(bus_b.tt),           64'h6);
        check_eq("xor_unst",  64'(bus_b.unstable),     64'd0);
        check_eq("xor_dutin", 64'(bus_b.dut_in),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
